// File: rtl/robo_controller.sv
// Maze-walking robot controller using a left-hand-wall rule.
// Each run starts with a start pulse in IDLE. In SENSE the controller reads the sensors and
// picks one action: stop, give up, turn left, advance, remove a barrier or turn right. After
// each command pulse it waits SETTLE cycles so the map memory can settle. A left turn is three
// clockwise turns followed by an advance, with no sensing in between.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle pulse; begins a run from IDLE
//   head_in     obstacle directly ahead
//   left_in     obstacle on the left
//   under_in    robot stands on the exit cell
//   barrier_in  obstacle ahead is a removable barrier
//   avancar     move one cell forward (one-cycle pulse)
//   girar       rotate 90 degrees clockwise (one-cycle pulse)
//   remover     clear the barrier ahead (one-cycle pulse)
//   busy        run in progress (not IDLE, DONE or FAIL)
//   done        exit reached (sticky until reset)
//   fail        step limit hit or robot boxed in (sticky until reset)
//   step_count  avancar pulses issued in the current run
module robo_controller #(
  parameter int unsigned SETTLE    = 1,
  parameter logic [7:0]  MAX_STEPS = 8'd255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       head_in,
  input  logic       left_in,
  input  logic       under_in,
  input  logic       barrier_in,
  output logic       avancar,
  output logic       girar,
  output logic       remover,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] step_count
);

  typedef enum logic [3:0] {
    StIdle, StSense, StAdvance, StTurnL, StTurnR, StRemove, StWait, StDone, StFail
  } state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [7:0] step_q, step_d;
  logic [2:0] spin_q, spin_d;    // consecutive right turns without an advance
  logic [1:0] lturn_q, lturn_d;  // girar pulses issued so far in a left turn; 0 = none pending
  logic [3:0] wait_q, wait_d;
  logic       avancar_q, avancar_d;
  logic       girar_q, girar_d;
  logic       remover_q, remover_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    spin_d  = spin_q;
    lturn_d = lturn_q;
    wait_d  = wait_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          step_d  = 8'd0;
          spin_d  = 3'd0;
          lturn_d = 2'd0;
          state_d = StSense;
        end
      end
      StSense: begin
        if (under_in) begin
          state_d = StDone;
        end else if (step_q == MAX_STEPS) begin
          state_d = StFail;
        end else if (spin_q == 3'd4) begin
          state_d = StFail;
        end else if (!left_in) begin
          lturn_d = 2'd0;
          state_d = StTurnL;
        end else if (!head_in) begin
          state_d = StAdvance;
        end else if (barrier_in) begin
          state_d = StRemove;
        end else begin
          state_d = StTurnR;
        end
      end
      StAdvance: begin
        step_d  = step_q + 8'd1;
        spin_d  = 3'd0;
        lturn_d = 2'd0;
        wait_d  = SettleLast;
        state_d = StWait;
      end
      StTurnL: begin
        lturn_d = lturn_q + 2'd1;
        wait_d  = SettleLast;
        state_d = StWait;
      end
      StTurnR: begin
        spin_d  = (spin_q == 3'd4) ? 3'd4 : spin_q + 3'd1;
        wait_d  = SettleLast;
        state_d = StWait;
      end
      StRemove: begin
        wait_d  = SettleLast;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (lturn_q == 2'd3) begin
          // Third clockwise turn done: the left turn completes with a forced advance.
          state_d = StAdvance;
        end else if (lturn_q != 2'd0) begin
          state_d = StTurnL;
        end else begin
          state_d = StSense;
        end
      end
      StDone:  state_d = StDone;
      StFail:  state_d = StFail;
      default: state_d = StIdle;
    endcase

    // Outputs follow the current state one cycle later.
    avancar_d = (state_q == StAdvance);
    girar_d   = (state_q == StTurnL) || (state_q == StTurnR);
    remover_d = (state_q == StRemove);
    busy_d    = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
    done_d    = (state_q == StDone);
    fail_d    = (state_q == StFail);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      step_q    <= 8'd0;
      spin_q    <= 3'd0;
      lturn_q   <= 2'd0;
      wait_q    <= 4'd0;
      avancar_q <= 1'b0;
      girar_q   <= 1'b0;
      remover_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      spin_q    <= spin_d;
      lturn_q   <= lturn_d;
      wait_q    <= wait_d;
      avancar_q <= avancar_d;
      girar_q   <= girar_d;
      remover_q <= remover_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign avancar    = avancar_q;
  assign girar      = girar_q;
  assign remover    = remover_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign step_count = step_q;

endmodule
